// File: rtl/systolic_ctrl_pkg.sv
// systolic_ctrl_pkg: shared state, opcode and error encodings for the systolic job sequencer
// Contents: state_t FSM encoding, OP_* job opcodes, ERR_* err_out codes.
package systolic_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_COMPUTE = 3'd3,
    S_DRAIN   = 3'd4,
    S_ERROR   = 3'd5
  } state_t;
  localparam logic [3:0] OP_MATMUL  = 4'h1;
  localparam logic [3:0] OP_REUSE_A = 4'h2;
  localparam logic [3:0] OP_RESEND  = 4'h3;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_OP      = 2'd1;
  localparam logic [1:0] ERR_FRAME   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
endpackage

// File: rtl/systolic_tx_drain.sv
// systolic_tx_drain: streams N_R result bytes from the result buffer to UART TX
// Ports: clk_in/rst_in (async active-low), start begins a drain from byte 0,
//   res_addr/res_rdata read the result buffer (data one cycle after address),
//   tx_valid/tx_data/tx_ready form the TX handshake, last_done marks the final handshake.
module systolic_tx_drain #(
  parameter int N_R = 36,
  parameter int AW  = 6
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          start,
  output logic [AW-1:0] res_addr,
  input  logic [7:0]    res_rdata,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready,
  output logic          last_done
);
  localparam logic [1:0] P_IDLE = 2'd0;
  localparam logic [1:0] P_ADDR = 2'd1;
  localparam logic [1:0] P_DATA = 2'd2;
  localparam logic [1:0] P_TX   = 2'd3;
  logic [1:0]    phase;
  logic [AW-1:0] idx;
  logic          last;
  assign last      = idx == AW'(N_R - 1);
  assign last_done = tx_valid & tx_ready & last;
  // The next address is issued as soon as a byte is captured, so its data is
  // already waiting when the handshake completes: two cycles per byte at best.
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      phase    <= P_IDLE;
      idx      <= '0;
      res_addr <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (phase == P_IDLE) begin
      if (start) begin
        phase    <= P_ADDR;
        idx      <= '0;
        res_addr <= '0;
      end
    end else if (phase == P_ADDR) begin
      phase <= P_DATA;
    end else if (phase == P_DATA) begin
      tx_valid <= 1'b1;
      tx_data  <= res_rdata;
      phase    <= P_TX;
      if (!last) res_addr <= idx + 1'b1;
    end else if (tx_ready) begin
      tx_valid <= 1'b0;
      phase    <= last ? P_IDLE : P_DATA;
      if (!last) idx <= idx + 1'b1;
    end
endmodule

// File: rtl/systolic_job_ctrl.sv
// systolic_job_ctrl: job sequencer for the 4-parallel Q8.24 systolic core
// Ports: clk_in/rst_in (async active-low); opcode_in/start_in request a job;
//   rx_valid/rx_data/rx_frame_err from UART RX; buf_* write the A/B operand buffers;
//   core_start/core_op/core_done talk to the core; res_addr/res_rdata read results;
//   tx_valid/tx_data/tx_ready feed UART TX; busy_out/done_out/err_out report status.
module systolic_job_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int N_A          = 36,
  parameter int N_B          = 36,
  parameter int N_R          = 36,
  parameter int AW           = 6,
  parameter int RX_TIMEOUT   = 100000,
  parameter int CORE_TIMEOUT = 4096
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [3:0]    opcode_in,
  input  logic          start_in,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  input  logic          rx_frame_err,
  output logic          buf_we,
  output logic          buf_sel,
  output logic [AW-1:0] buf_addr,
  output logic [7:0]    buf_wdata,
  output logic          core_start,
  output logic [3:0]    core_op,
  input  logic          core_done,
  output logic [AW-1:0] res_addr,
  input  logic [7:0]    res_rdata,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready,
  output logic          busy_out,
  output logic          done_out,
  output logic [1:0]    err_out
);
  localparam int GW = $clog2(RX_TIMEOUT + 1);
  localparam int CW = $clog2(CORE_TIMEOUT + 1);
  state_t        state;
  logic          start_q, start_edge, a_valid, r_valid, in_load, rx_end, go_drain, last_done;
  logic [AW-1:0] cnt, last_idx;
  logic [GW-1:0] gap;
  logic [CW-1:0] ccnt;
  assign start_edge = start_in & ~start_q;
  assign in_load    = state == S_LOAD_A || state == S_LOAD_B;
  assign last_idx   = state == S_LOAD_A ? AW'(N_A - 1) : AW'(N_B - 1);
  assign rx_end     = cnt == last_idx;
  assign busy_out   = in_load || state == S_COMPUTE || state == S_DRAIN;
  // core_done in the core_start cycle belongs to nobody and is ignored.
  assign go_drain   = (state == S_IDLE && start_edge && opcode_in == OP_RESEND && r_valid) ||
                      (state == S_COMPUTE && !core_start && core_done);
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      state      <= S_IDLE;
      start_q    <= 1'b0;
      a_valid    <= 1'b0;
      r_valid    <= 1'b0;
      done_out   <= 1'b0;
      err_out    <= ERR_NONE;
      cnt        <= '0;
      gap        <= '0;
      ccnt       <= '0;
      core_start <= 1'b0;
      core_op    <= '0;
      buf_we     <= 1'b0;
      buf_sel    <= 1'b0;
      buf_addr   <= '0;
      buf_wdata  <= '0;
    end else begin
      start_q    <= start_in;
      buf_we     <= 1'b0;
      core_start <= 1'b0;
      if (state == S_IDLE && start_edge) begin
        core_op  <= opcode_in;
        done_out <= 1'b0;
        cnt      <= '0;
        gap      <= '0;
        ccnt     <= '0;
        if (opcode_in == OP_MATMUL) state <= S_LOAD_A;
        else if (opcode_in == OP_REUSE_A && a_valid) state <= S_LOAD_B;
        else if (go_drain) state <= S_DRAIN;
        else begin
          state   <= S_ERROR;
          err_out <= ERR_OP;
        end
      end else if (state == S_ERROR && start_edge) begin
        state   <= S_IDLE;
        err_out <= ERR_NONE;
      end else if (in_load) begin
        if (rx_frame_err || gap == GW'(RX_TIMEOUT)) begin
          state   <= S_ERROR;
          err_out <= rx_frame_err ? ERR_FRAME : ERR_TIMEOUT;
          // Only a partly overwritten A buffer is untrustworthy.
          if (state == S_LOAD_A && cnt != '0) a_valid <= 1'b0;
        end else if (rx_valid) begin
          buf_we    <= 1'b1;
          buf_sel   <= state == S_LOAD_B;
          buf_addr  <= cnt;
          buf_wdata <= rx_data;
          gap       <= '0;
          cnt       <= rx_end ? '0 : cnt + 1'b1;
          if (rx_end && state == S_LOAD_A) begin
            a_valid <= 1'b1;
            state   <= S_LOAD_B;
          end else if (rx_end) begin
            state      <= S_COMPUTE;
            core_start <= 1'b1;
          end
        end else gap <= gap + 1'b1;
      end else if (state == S_COMPUTE) begin
        ccnt <= ccnt + 1'b1;
        if (go_drain) begin
          state   <= S_DRAIN;
          r_valid <= 1'b1;
        end else if (ccnt == CW'(CORE_TIMEOUT)) begin
          state   <= S_ERROR;
          err_out <= ERR_TIMEOUT;
          r_valid <= 1'b0;
        end
      end else if (state == S_DRAIN && last_done) begin
        state    <= S_IDLE;
        done_out <= 1'b1;
      end
    end
  systolic_tx_drain #(.N_R(N_R), .AW(AW)) u_drain (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .start     (go_drain),
    .res_addr  (res_addr),
    .res_rdata (res_rdata),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .last_done (last_done)
  );
endmodule

// File: tb/tb_systolic_job_ctrl.sv
// tb_systolic_job_ctrl: directed self-checking bench for systolic_job_ctrl
module tb_systolic_job_ctrl;
  localparam int AW = 6;
  localparam int NB = 36;
  logic          clk_in = 1'b0;
  logic          rst_in, start_in, rx_valid, rx_frame_err, core_done, tx_ready;
  logic [3:0]    opcode_in;
  logic [7:0]    rx_data, res_rdata, buf_wdata, tx_data;
  logic          buf_we, buf_sel, core_start, tx_valid, busy_out, done_out;
  logic [AW-1:0] buf_addr, res_addr;
  logic [3:0]    core_op;
  logic [1:0]    err_out;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, a_cnt = 0, b_cnt = 0, a_bad = 0, b_bad = 0, n_cs = 0;
  int tx_n = 0, tx_bad = 0, tx_first = 0, tx_last = 0, stall_bad = 0;
  logic stalled = 1'b0;
  logic [7:0] held = '0;
  logic core_hold = 1'b0;
  int wi, n_rst;
  always #5 clk_in = ~clk_in;
  systolic_job_ctrl #(
    .N_A(NB), .N_B(NB), .N_R(NB), .AW(AW), .RX_TIMEOUT(200), .CORE_TIMEOUT(100)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .opcode_in(opcode_in), .start_in(start_in),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_frame_err(rx_frame_err),
    .buf_we(buf_we), .buf_sel(buf_sel), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .core_start(core_start), .core_op(core_op), .core_done(core_done),
    .res_addr(res_addr), .res_rdata(res_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy_out(busy_out), .done_out(done_out), .err_out(err_out)
  );
  function automatic logic [7:0] res_byte(input int k);
    return 8'(k * 5 + 17);
  endfunction
  always @(posedge clk_in) res_rdata <= res_byte(int'(res_addr));
  always @(negedge clk_in) begin
    cyc++;
    if (start_in) begin
      a_cnt = 0; b_cnt = 0; a_bad = 0; b_bad = 0; n_cs = 0;
      tx_n = 0; tx_bad = 0; stall_bad = 0; stalled = 1'b0;
    end
    if (buf_we && !buf_sel) begin
      if (buf_addr !== AW'(a_cnt) || buf_wdata !== 8'(a_cnt)) a_bad++;
      a_cnt++;
    end
    if (buf_we && buf_sel) begin
      if (buf_addr !== AW'(b_cnt) || buf_wdata !== ~8'(b_cnt)) b_bad++;
      b_cnt++;
    end
    if (core_start) n_cs++;
    if (stalled && (!tx_valid || tx_data !== held)) stall_bad++;
    if (tx_valid && tx_ready) begin
      if (tx_data !== res_byte(tx_n)) tx_bad++;
      if (tx_n == 0) tx_first = cyc;
      tx_last = cyc;
      tx_n++;
    end
    stalled = tx_valid & ~tx_ready;
    held    = tx_data;
  end
  initial begin
    core_done = 1'b0;
    forever begin
      @(posedge clk_in); #1;
      if (core_start && !core_hold) begin
        repeat (20) @(posedge clk_in);
        #1 core_done = 1'b1;
        @(posedge clk_in);
        #1 core_done = 1'b0;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask
  task automatic pulse_start(input logic [3:0] op);
    opcode_in = op;
    start_in  = 1'b1;
    cycles(1);
    start_in  = 1'b0;
    cycles(1);
  endtask
  task automatic send_byte(input logic [7:0] d, input logic fe);
    rx_valid     = 1'b1;
    rx_data      = d;
    rx_frame_err = fe;
    cycles(1);
    rx_valid     = 1'b0;
    rx_frame_err = 1'b0;
    cycles(2);
  endtask
  task automatic load(input int n, input bit inv);
    for (int k = 0; k < n; k++) send_byte(inv ? ~8'(k) : 8'(k), 1'b0);
  endtask
  task automatic drain(input int mode);
    int i = 0;
    while (busy_out && i < 2000) begin
      tx_ready = mode == 0 || i % 3 == 0;
      rx_valid = i == 7;
      rx_data  = 8'hAA;
      cycles(1);
      i++;
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    chk("drain_bound", 32'(i < 2000), 1);
  endtask
  task automatic wait_err(input int lim, output int i);
    i = 0;
    while (err_out == 2'd0 && i < lim) begin
      cycles(1);
      i++;
    end
  endtask
  initial begin
    rst_in = 1'b0; start_in = 1'b0; opcode_in = '0; rx_valid = 1'b0;
    rx_data = '0; rx_frame_err = 1'b0; tx_ready = 1'b1;
    cycles(3);
    chk("rst_ctrl", {tx_valid, busy_out, buf_we, core_start, done_out, err_out, core_op}, 0);
    chk("rst_data", {res_addr, tx_data, buf_addr, buf_sel, buf_wdata}, 0);
    rst_in = 1'b1;
    cycles(2);
    pulse_start(4'h2);
    chk("reuse_noA_err", err_out, 1);
    chk("reuse_noA_busy", busy_out, 0);
    pulse_start(4'h0);
    chk("err_clear", err_out, 0);
    pulse_start(4'h7);
    chk("bad_op_err", err_out, 1);
    pulse_start(4'h0);
    pulse_start(4'h1);
    chk("job_busy", busy_out, 1);
    load(NB, 1'b0);
    load(NB, 1'b1);
    drain(0);
    chk("job_a_writes", a_cnt, NB);
    chk("job_b_writes", b_cnt, NB);
    chk("job_a_content", a_bad, 0);
    chk("job_b_content", b_bad, 0);
    chk("job_core_starts", n_cs, 1);
    chk("job_tx_count", tx_n, NB);
    chk("job_tx_data", tx_bad, 0);
    chk("job_tx_rate", tx_last - tx_first, 2 * (NB - 1));
    chk("job_done", done_out, 1);
    chk("job_err", err_out, 0);
    pulse_start(4'h2);
    chk("reuse_done_clr", done_out, 0);
    chk("reuse_busy", busy_out, 1);
    load(NB, 1'b1);
    drain(0);
    chk("reuse_a_writes", a_cnt, 0);
    chk("reuse_b_writes", b_cnt, NB);
    chk("reuse_b_content", b_bad, 0);
    chk("reuse_tx_data", tx_bad, 0);
    chk("reuse_done", done_out, 1);
    pulse_start(4'h3);
    drain(1);
    chk("resend_writes", a_cnt + b_cnt, 0);
    chk("resend_core_starts", n_cs, 0);
    chk("resend_tx_count", tx_n, NB);
    chk("resend_tx_data", tx_bad, 0);
    chk("resend_stall_hold", stall_bad, 0);
    chk("resend_done", done_out, 1);
    pulse_start(4'h1);
    load(10, 1'b0);
    send_byte(8'd10, 1'b1);
    chk("frame_err", err_out, 2);
    chk("frame_busy", busy_out, 0);
    chk("frame_writes", a_cnt, 10);
    chk("frame_content", a_bad, 0);
    pulse_start(4'h0);
    chk("frame_clear", err_out, 0);
    pulse_start(4'h2);
    chk("frame_a_invalid", err_out, 1);
    pulse_start(4'h0);
    pulse_start(4'h1);
    load(NB, 1'b0);
    wait_err(500, wi);
    chk("rx_timeout_err", err_out, 3);
    chk("rx_timeout_window", 32'(wi >= 190 && wi <= 210), 1);
    pulse_start(4'h0);
    core_hold = 1'b1;
    pulse_start(4'h2);
    chk("core_to_busy", busy_out, 1);
    load(NB, 1'b1);
    wait_err(400, wi);
    chk("core_timeout_err", err_out, 3);
    chk("core_timeout_busy", busy_out, 0);
    pulse_start(4'h0);
    pulse_start(4'h3);
    chk("core_to_r_invalid", err_out, 1);
    pulse_start(4'h0);
    core_hold = 1'b0;
    pulse_start(4'h2);
    load(NB, 1'b1);
    drain(0);
    chk("prep_done", done_out, 1);
    pulse_start(4'h3);
    wi = 0;
    while (tx_n < 5 && wi < 200) begin
      cycles(1);
      wi++;
    end
    chk("drain_reach_5", tx_n, 5);
    n_rst = tx_n;
    rst_in = 1'b0;
    cycles(1);
    chk("midrst_ctrl", {tx_valid, busy_out, buf_we, core_start, done_out, err_out, core_op}, 0);
    chk("midrst_data", {res_addr, tx_data, buf_addr, buf_sel, buf_wdata}, 0);
    cycles(5);
    chk("midrst_no_tx", tx_n, n_rst);
    rst_in = 1'b1;
    cycles(2);
    pulse_start(4'h3);
    chk("midrst_resend_err", err_out, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
